apb_bridge_arbiter: RTL and testbench

- Two-master round-robin arbiter and transfer sequencer in front of the AHB-to-APB bridge's slave port.
- Accepts single-word read/write requests from two local masters over a req/ack handshake.
- Drives the bridge's AHB-side address/data phases (haddr, htrans, hwrite, hwdata, hsel_apb) and returns read data and error status to the winning master.
- Adds a wait-state timeout so a hung APB slave cannot lock the bridge.

---
 rtl/apb_bridge_arbiter.sv | 151 +++++++++++++++
 tb/tb_apb_bridge_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_arbiter.sv
// Two-master round-robin arbiter and single-transfer sequencer for the AHB side of an AHB-to-APB bridge.
// Each transfer runs IDLE -> ADDR -> DATA -> RESP. DATA waits are bounded by a timeout that reports an error.
module apb_bridge_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [1:0]        grant_o,
  output logic [ADDR_W-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [DATA_W-1:0] hwdata_o,
  output logic              hsel_apb_o,
  input  logic [DATA_W-1:0] hrdata_i,
  input  logic              hready_i,
  input  logic [1:0]        hresp_i
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  // The abort fires on the wait cycle that would bring the count up to TIMEOUT.
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [15:0]       r_cnt;
  logic              w_any_req;
  logic              w_pick_m1;
  logic              w_timeout;

  assign w_any_req = m0_req | m1_req;
  // On a tie the master that did not own the previous transfer wins.
  assign w_pick_m1 = m1_req & (~m0_req | ~r_last);
  assign w_timeout = ~hready_i & (r_cnt == LP_TO_LAST);

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_state_next = S_ADDR;
      S_ADDR: if (hready_i) w_state_next = S_DATA;
      S_DATA: if (hready_i || w_timeout) w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_last  <= 1'b1;
      r_grant <= 2'b00;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick_m1 ? 2'b10 : 2'b01;
            r_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
            r_write <= w_pick_m1 ? m1_write : m0_write;
            r_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
          end
        end
        S_DATA: begin
          if (hready_i) begin
            r_rdata <= r_write ? '0 : hrdata_i;
            r_err   <= (hresp_i != 2'b00);
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_last  <= r_grant[1];
          r_grant <= 2'b00;
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant_o = r_grant;
  assign rdata_o = r_rdata;
  assign err_o   = r_err;

  always_comb begin
    haddr_o    = '0;
    htrans_o   = 2'b00;
    hwrite_o   = 1'b0;
    hwdata_o   = '0;
    hsel_apb_o = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (r_state)
      S_ADDR: begin
        hsel_apb_o = 1'b1;
        htrans_o   = 2'b10;
        haddr_o    = r_addr;
        hwrite_o   = r_write;
      end
      S_DATA: begin
        haddr_o  = r_addr;
        hwrite_o = r_write;
        hwdata_o = r_wdata;
      end
      S_RESP: begin
        m0_ack = r_grant[0];
        m1_ack = r_grant[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Directed bench for apb_bridge_arbiter: a table of single transfers plus contention and mid-transfer reset sequences.
module tb_apb_bridge_arbiter;

  logic        hclk;
  logic        hreset_n;
  logic        m0_req, m0_write, m0_ack;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_write, m1_ack;
  logic [31:0] m1_addr, m1_wdata;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [1:0]  grant_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [31:0] hwdata_o;
  logic        hsel_apb_o;
  logic [31:0] hrdata_i;
  logic        hready_i;
  logic [1:0]  hresp_i;

  int checks = 0;
  int errors = 0;

  apb_bridge_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata_o(rdata_o), .err_o(err_o), .grant_o(grant_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hwdata_o(hwdata_o),
    .hsel_apb_o(hsel_apb_o), .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        master;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    int          aw;
    int          dw;
    logic        tout;
    int          exp_ack;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, grant_o, 2'b00);
    check({tag, "_rdata"}, rdata_o, 32'h0);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_acks"}, {m1_ack, m0_ack}, 2'b00);
    check({tag, "_htrans"}, htrans_o, 2'b00);
    check({tag, "_hsel"}, hsel_apb_o, 1'b0);
  endtask

  // Starts at a falling edge with the DUT in IDLE; returns at the falling edge of the IDLE cycle after the ack.
  task automatic run_txn(input int idx, input vec_t v);
    logic [1:0] exp_g;
    int d0;
    exp_g = v.master ? 2'b10 : 2'b01;
    d0 = 2 + v.aw;
    if (!v.master) begin
      m0_req = 1'b1; m0_addr = v.addr; m0_write = v.write; m0_wdata = v.wdata;
    end else begin
      m1_req = 1'b1; m1_addr = v.addr; m1_write = v.write; m1_wdata = v.wdata;
    end
    hrdata_i = v.hrdata;
    hresp_i  = v.hresp;
    hready_i = 1'b0;
    for (int c = 1; c <= v.exp_ack; c++) begin
      @(negedge hclk);
      if (c < d0) begin
        check("addr_htrans", htrans_o, 2'b10);
        check("addr_hsel", hsel_apb_o, 1'b1);
        check("addr_haddr", haddr_o, v.addr);
        check("addr_hwrite", hwrite_o, v.write);
        check("addr_grant", grant_o, exp_g);
        hready_i = (c == d0 - 1);
      end else if (c < v.exp_ack) begin
        check("data_htrans", htrans_o, 2'b00);
        check("data_hsel", hsel_apb_o, 1'b0);
        check("data_haddr", haddr_o, v.addr);
        check("data_acks", {m1_ack, m0_ack}, 2'b00);
        if (v.write) check("data_hwdata", hwdata_o, v.wdata);
        hready_i = !v.tout && ((c - d0) == v.dw);
      end else begin
        check("resp_acks", {m1_ack, m0_ack}, exp_g);
        check("resp_rdata", rdata_o, v.exp_rdata);
        check("resp_err", err_o, v.exp_err);
        check("resp_grant", grant_o, exp_g);
        m0_req = 1'b0;
        m1_req = 1'b0;
        hready_i = 1'b0;
      end
    end
    @(negedge hclk);
    check_idle("post_txn");
    $display("txn %0d: master %0d %s addr %08h rdata %08h err %0d", idx, v.master,
             v.write ? "write" : "read ", v.addr, v.exp_rdata, v.exp_err);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_0000, 2'b00, 0, 3, 1'b0, 6, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'hBAD0_0001, 2'b01, 0, 0, 1'b0, 3, 32'hBAD0_0001, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 2'b00, 0, 0, 1'b1, 6, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0050, 32'hA5A5_0F0F, 32'h1111_2222, 2'b00, 2, 3, 1'b0, 8, 32'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0060, 32'h0, 32'h0BAD_F00D, 2'b00, 0, 2, 1'b0, 5, 32'h0BAD_F00D, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0070, 32'h0, 32'h7777_8888, 2'b10, 1, 1, 1'b0, 5, 32'h7777_8888, 1'b1};

    hreset_n = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_write = 1'b0; m0_wdata = '0;
    m1_req = 1'b0; m1_addr = '0; m1_write = 1'b0; m1_wdata = '0;
    hrdata_i = '0; hready_i = 1'b0; hresp_i = 2'b00;
    #2 hreset_n = 1'b0;
    repeat (2) @(negedge hclk);
    check_idle("reset");
    check("reset_haddr", haddr_o, 32'h0);
    check("reset_hwrite", hwrite_o, 1'b0);
    check("reset_hwdata", hwdata_o, 32'h0);
    hreset_n = 1'b1;
    @(negedge hclk);

    // Both masters request from reset and re-request after each ack: strict alternation starting with m0.
    m0_req = 1'b1; m0_addr = 32'h100; m0_write = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h200; m1_write = 1'b0;
    hready_i = 1'b1; hrdata_i = 32'h0000_C0DE; hresp_i = 2'b00;
    for (int c = 1; c <= 16; c++) begin
      int k;
      int ph;
      logic [1:0] own;
      @(negedge hclk);
      k = (c - 1) / 4;
      ph = (c - 1) % 4;
      own = (k % 2 == 0) ? 2'b01 : 2'b10;
      check("cont_grant", grant_o, (ph < 3) ? own : 2'b00);
      check("cont_acks", {m1_ack, m0_ack}, (ph == 2) ? own : 2'b00);
      if (ph == 0) check("cont_haddr", haddr_o, own[1] ? 32'h200 : 32'h100);
      if (ph == 2) begin
        check("cont_rdata", rdata_o, 32'h0000_C0DE);
        $display("contention ack cycle %0d: owner m%0d", c, own[1]);
        if (c == 15) begin
          m0_req = 1'b0; m1_req = 1'b0;
        end else if (own[0]) begin
          m0_req = 1'b0;
        end else begin
          m1_req = 1'b0;
        end
      end
      if (ph == 3 && c < 16) begin
        m0_req = 1'b1; m1_req = 1'b1;
      end
    end
    hready_i = 1'b0;
    check_idle("cont_end");

    for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

    // Reset asserted during a DATA wait: outputs clear at once and no ack follows.
    m0_req = 1'b1; m0_addr = 32'h90; m0_write = 1'b1; m0_wdata = 32'hFEED_0001;
    hready_i = 1'b0;
    @(negedge hclk);
    check("rst_op_addr_phase", htrans_o, 2'b10);
    hready_i = 1'b1;
    @(negedge hclk);
    check("rst_op_data_hwdata", hwdata_o, 32'hFEED_0001);
    hready_i = 1'b0;
    @(negedge hclk);
    hreset_n = 1'b0;
    #1;
    check_idle("rst_op");
    check("rst_op_haddr", haddr_o, 32'h0);
    check("rst_op_hwdata", hwdata_o, 32'h0);
    m0_req = 1'b0;
    hready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      check("rst_hold_acks", {m1_ack, m0_ack}, 2'b00);
    end
    hready_i = 1'b0;
    hreset_n = 1'b1;
    $display("reset mid-transfer: outputs cleared, no ack");
    run_txn(7, '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 2'b00, 0, 0, 1'b0, 3, 32'hCAFE_F00D, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
